// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Time-multiplexed driver for NUM_DIGITS seven-segment digits. Each digit owns
//   a slot of REFRESH_DIV clocks. The first BLANK_CYCLES clocks of a slot are
//   dead time with everything deselected. Display data is double-buffered:
//   loads land in a pending buffer, which is promoted to the active buffer
//   only at a frame boundary.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : 0 forces outputs inactive (counters/buffers keep running)
//   lzb_en       : leading-zero blanking enable
//   load         : 1-cycle strobe capturing digits_in / dp_in
//   digits_in    : 4-bit code per digit, [3:0] = digit 0
//   dp_in        : decimal point per digit
//   seg_data     : registered segments {dp,g,f,e,d,c,b,a}
//   digit_sel    : registered one-hot digit select, bit i = digit i
//   frame_done   : 1-cycle pulse after each frame boundary
//   update_ack   : 1-cycle pulse when new data becomes active
module seven_segment_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1024,
  parameter int BLANK_CYCLES   = 16,
  parameter int HEX_EN         = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    lzb_en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [7:0]              seg_data,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done,
  output logic                    update_ack
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [7:0]    SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF =
    (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                    pend_vld_q, pend_vld_d;
  logic                    fd_q, ack_q, ack_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;

  logic                    tick, boundary, lead, in_dead;
  logic [NUM_DIGITS-1:0]   blank_mask, onehot;
  logic [3:0]              cur_code;
  logic                    cur_dp, cur_blank;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h07;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h6F;
      4'hA:    glyph = (HEX_EN != 0) ? 7'h77 : 7'h00;
      4'hB:    glyph = (HEX_EN != 0) ? 7'h7C : 7'h00;
      4'hC:    glyph = (HEX_EN != 0) ? 7'h39 : 7'h00;
      4'hD:    glyph = (HEX_EN != 0) ? 7'h5E : 7'h00;
      4'hE:    glyph = (HEX_EN != 0) ? 7'h79 : 7'h00;
      default: glyph = (HEX_EN != 0) ? 7'h71 : 7'h00;
    endcase
  endfunction

  assign tick     = (presc_q == PRESC_MAX);
  assign boundary = tick && (idx_q == IDX_MAX);
  assign presc_d  = tick ? '0 : presc_q + 1'b1;
  assign idx_d    = tick ? ((idx_q == IDX_MAX) ? '0 : idx_q + 1'b1) : idx_q;

  // A load on the boundary tick bypasses pending and wins over older pending
  // data; the active buffer is only ever written on a boundary.
  always_comb begin
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    if (boundary && load) begin
      act_dig_d  = digits_in;
      act_dp_d   = dp_in;
      pend_vld_d = 1'b0;
      ack_d      = 1'b1;
    end else if (boundary && pend_vld_q) begin
      act_dig_d  = pend_dig_q;
      act_dp_d   = pend_dp_q;
      pend_vld_d = 1'b0;
      ack_d      = 1'b1;
    end else if (load) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end
  end

  // Leading zeros are blanked from the top digit down; digit 0 always shows.
  always_comb begin
    lead       = lzb_en;
    blank_mask = '0;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      if (lead && (act_dig_q[4*(NUM_DIGITS-1-k) +: 4] == 4'h0)) begin
        blank_mask[NUM_DIGITS-1-k] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
  end

  always_comb begin
    cur_code  = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    onehot    = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_code  = act_dig_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_blank = blank_mask[i];
        onehot[i] = 1'b1;
      end
    end
  end

  assign in_dead = (BLANK_CYCLES > 0) && (presc_q < BLANK_END);

  always_comb begin
    seg_d = SEG_OFF;
    sel_d = SEL_OFF;
    if (enable && !in_dead) begin
      seg_d = {cur_dp, cur_blank ? 7'h00 : glyph(cur_code)} ^ SEG_OFF;
      sel_d = onehot ^ SEL_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      act_dig_q  <= '0;
      act_dp_q   <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      fd_q       <= 1'b0;
      ack_q      <= 1'b0;
      seg_q      <= SEG_OFF;
      sel_q      <= SEL_OFF;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      act_dig_q  <= act_dig_d;
      act_dp_q   <= act_dp_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      fd_q       <= boundary;
      ack_q      <= ack_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
    end
  end

  assign seg_data   = seg_q;
  assign digit_sel  = sel_q;
  assign frame_done = fd_q;
  assign update_ack = ack_q;

endmodule
